mealy_seq_detector: RTL

Parametrised successor to the team's fixed 5-state Mealy detector on a serial input bit. It detects a runtime-loadable bit pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection. The match output is registered and glitch-free, with no clock gating. It also keeps a saturating match counter, and sits between a serial input pin and the status outputs of a TT-style top.

---
 rtl/mealy_seq_pkg.sv | 24 ++
 rtl/mealy_seq_detector_sat_counter.sv | 35 +++
 rtl/mealy_seq_detector.sv | 111 +++++++++++
 3 files changed

// File: rtl/mealy_seq_pkg.sv
// Shared types and helpers for the parametrised Mealy sequence detector.
package mealy_seq_pkg;

   // Pattern length that disables detection entirely.
   localparam int LEN_DISABLED = 0;

   // What the detector does with the current cycle.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_SHIFT = 2'd2
   } op_e;

   // Width needed to hold a count of 0..max_len history bits.
   function automatic int fill_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Oversized lengths fall back to the longest pattern the history can hold.
   function automatic int clamp_len(input int len, input int max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered all-ones flag.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   logic [CNT_W-1:0] count_nxt;

   // Next count: clear wins, increment stops at all-ones.
   always_comb begin
      count_nxt = count;
      if (clr)
         count_nxt = '0;
      else if (inc && !(&count))
         count_nxt = count + CNT_W'(1);
   end

   // Flag is registered together with the count so both change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         sat   <= 1'b0;
      end else begin
         count <= count_nxt;
         sat   <= &count_nxt;
      end
   end

endmodule

// File: rtl/mealy_seq_detector.sv
// Runtime-loadable serial pattern detector with registered match pulse and
// saturating match counter.
//
// state (fill) | meaning
// 0            | history cleared, no valid bits yet
// 1..MAX_LEN-1 | that many valid history bits since the last clear
// MAX_LEN      | history full, stays here until a clear
module mealy_seq_detector
   import mealy_seq_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         din_valid,
   input  logic                         din,
   input  logic                         pat_load,
   input  logic [MAX_LEN-1:0]           pat_in,
   input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
   input  logic                         overlap_mode,
   output logic                         match,
   output logic [$clog2(MAX_LEN+1)-1:0] fill,
   output logic [CNT_W-1:0]             match_count,
   output logic                         count_sat
);

   localparam int FILL_W = fill_w(MAX_LEN);

   // The oldest stored bit would only matter for a pattern longer than
   // MAX_LEN, so the history keeps MAX_LEN-1 bits.
   logic [MAX_LEN-1:0] pattern_q;
   logic [MAX_LEN-2:0] history_q;
   logic [FILL_W-1:0]  len_q;
   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] len_mask;
   logic [FILL_W-1:0]  fill_inc;
   logic               enough;
   logic               hit;
   op_e                op;

   // Load beats a same-cycle data bit.
   always_comb begin
      op = OP_HOLD;
      if (pat_load)
         op = OP_LOAD;
      else if (din_valid)
         op = OP_SHIFT;
   end

   // Mealy term: compare the newest len bits (including din) against the pattern.
   always_comb begin
      cand = {history_q, din};
      for (int i = 0; i < MAX_LEN; i++)
         len_mask[i] = (i < int'(len_q));
      enough   = ({1'b0, fill_q_ext(fill)} + (FILL_W+1)'(1)) >= {1'b0, len_q};
      fill_inc = (fill == FILL_W'(MAX_LEN)) ? fill : fill + FILL_W'(1);
      hit      = (op == OP_SHIFT) && (len_q != FILL_W'(LEN_DISABLED)) && enough &&
                 (((cand ^ pattern_q) & len_mask) == '0);
   end

   function automatic logic [FILL_W-1:0] fill_q_ext(input logic [FILL_W-1:0] f);
      return f;
   endfunction

   // Pattern registers, history shift register, fill state and match pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_q <= '0;
         len_q     <= '0;
         history_q <= '0;
         fill      <= '0;
         match     <= 1'b0;
      end else begin
         case (op)
            OP_LOAD: begin
               pattern_q <= pat_in;
               len_q     <= FILL_W'(clamp_len(int'(pat_len), MAX_LEN));
               history_q <= '0;
               fill      <= '0;
               match     <= 1'b0;
            end
            OP_SHIFT: begin
               match <= hit;
               if (hit && !overlap_mode) begin
                  history_q <= '0;
                  fill      <= '0;
               end else begin
                  history_q <= cand[MAX_LEN-2:0];
                  fill      <= fill_inc;
               end
            end
            default: begin
               match <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hit),
      .clr   (op == OP_LOAD),
      .count (match_count),
      .sat   (count_sat)
   );

endmodule
